// File: rtl/booth_pkg.sv
// Shared constants and state encoding for the sequential radix-4 Booth multiplier.
package booth_pkg;

   localparam int WIDTH  = 16;
   localparam int NDIG   = 8;
   localparam int CNT_W  = 3;
   localparam int PP_W   = 17;
   localparam int PROD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/booth3bits.sv
// Radix-4 Booth partial-product encoder: one 3-bit multiplier window selects 0, +-a or +-2a.
module booth3bits
   import booth_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [2:0]       window,
   output logic [PP_W-1:0]  pp
);

   logic [PP_W-1:0] a_x;
   logic [PP_W-1:0] a_2x;

   assign a_x  = {a[WIDTH-1], a};
   assign a_2x = {a, 1'b0};

   always_comb begin
      pp = '0;
      case (window)
         3'b001, 3'b010: pp = a_x;
         3'b011:         pp = a_2x;
         3'b100:         pp = -a_2x;
         3'b101, 3'b110: pp = -a_x;
         default:        pp = '0;
      endcase
   end

endmodule

// File: rtl/booth_seq_accum.sv
// Iterative 16x16 signed multiplier: one Booth digit per cycle, 8 digit cycles per product,
// valid/ready handshakes on operand and result sides.
module booth_seq_accum
   import booth_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] product,
   output logic              busy
);

   // Handshake rule: a transfer happens on a rising edge where valid and ready are both high;
   // the producer holds data stable while valid is high and ready is low.

   state_t             state;
   state_t             state_nx;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH:0]     b_ext;
   logic [CNT_W-1:0]   cnt;
   logic [PROD_W-1:0]  acc;

   logic [4:0]         sh_idx;
   logic [2:0]         window;
   logic [PP_W-1:0]    pp;
   logic               pp_sign;
   logic [PROD_W-1:0]  pp_ext;
   logic [PROD_W-1:0]  addend;
   logic               accept;
   logic               last_digit;

   booth3bits u_enc (
      .a      (a_r),
      .window (window),
      .pp     (pp)
   );

   assign sh_idx     = {1'b0, cnt, 1'b0};
   assign window     = b_ext[sh_idx +: 3];
   assign accept     = in_valid && in_ready;
   assign last_digit = (cnt == CNT_W'(NDIG - 1));

   // The 17-bit pp cannot tell +2^16 from -2^16, so the sign comes from the digit sign
   // and the multiplicand sign rather than from pp[16].
   assign pp_sign = (pp != '0) && (window[2] ^ a_r[WIDTH-1]);
   assign pp_ext  = {{(PROD_W - PP_W){pp_sign}}, pp};
   assign addend  = pp_ext << sh_idx;

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (in_valid) state_nx = ST_CALC;
         ST_CALC: if (last_digit) state_nx = ST_DONE;
         ST_DONE: if (out_ready) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         ST_IDLE: in_ready = 1'b1;
         ST_CALC: busy = 1'b1;
         ST_DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r   <= '0;
         b_ext <= '0;
         cnt   <= '0;
         acc   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_r   <= a;
                  b_ext <= {b, 1'b0};
                  cnt   <= '0;
                  acc   <= '0;
               end
            end
            ST_CALC: begin
               acc <= acc + addend;
               cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign product = acc;

endmodule

// File: tb/tb_booth_seq_accum.sv
// Self-checking bench for booth_seq_accum: directed cases plus randomized operands and gaps.
module tb_booth_seq_accum;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] product;
   logic        busy;

   logic [31:0] exp_q[$];
   int          checks;
   int          errors;

   booth_seq_accum dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [15:0] ma, input logic [15:0] mb);
      logic signed [15:0] sa;
      logic signed [15:0] sb;
      logic signed [31:0] p;
      sa = ma;
      sb = mb;
      p  = sa * sb;
      return p;
   endfunction

   // One full transaction; hold = cycles of out_ready=0 in DONE, noisy = toggle in_valid/a/b while busy.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_in, input logic [31:0] texp,
                         input int hold, input bit noisy);
      int k;
      out_ready = (hold == 0);
      in_valid  = 1'b1;
      a         = ta;
      b         = tb_in;
      k = 0;
      while (!in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("accept_ready", 32'(in_ready), 32'd1);
      exp_q.push_back(texp);
      @(negedge clk);
      in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      check("in_ready_calc", 32'(in_ready), 32'd0);
      check("busy_calc", 32'(busy), 32'd1);
      k = 1;
      while (!out_valid && k < 20) begin
         @(negedge clk);
         k++;
         if (noisy) begin
            in_valid = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
         end
      end
      check("latency_edges", 32'(k - 1), 32'd8);
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_product", product, texp);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      if (exp_q.size() == 0) check("scoreboard_empty", 32'd0, 32'd1);
      else check("product", product, exp_q.pop_front());
      check("out_valid_done", 32'(out_valid), 32'd1);
      @(negedge clk);
      check("out_valid_after", 32'(out_valid), 32'd0);
      check("in_ready_after", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_product", product, 32'd0);
      @(negedge clk);

      run_op(16'd3, 16'd5, 32'h0000000F, 0, 1'b0);
      run_op(16'hFFFF, 16'hFFFF, 32'h00000001, 0, 1'b0);
      run_op(16'hFFF9, 16'd6, 32'hFFFFFFD6, 0, 1'b0);
      run_op(16'h8000, 16'h8000, 32'h40000000, 0, 1'b0);
      run_op(16'h7FFF, 16'h8000, 32'hC0008000, 0, 1'b0);
      run_op(16'd0, 16'd12345, 32'h00000000, 0, 1'b0);
      run_op(16'd100, 16'hFFFD, 32'hFFFFFED4, 5, 1'b0);

      // Reset during the 4th CALC cycle, with in_valid raised alongside it.
      in_valid = 1'b1;
      a = 16'd77;
      b = 16'd99;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      rst = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      check("rst_no_accept", 32'(busy), 32'd0);
      run_op(16'd2, 16'd2, 32'h00000004, 0, 1'b0);

      for (int n = 0; n < 3000; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (n % 16 == 0) ra = 16'h8000;
         if (n % 16 == 1) rb = 16'h8000;
         run_op(ra, rb, model(ra, rb), int'($urandom_range(0, 3)), 1'b1);
         repeat ($urandom_range(0, 2)) begin
            check("gap_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
         end
      end
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
